// File: rtl/ps2_mouse_host_ctrl_pkg.sv
// Shared PS/2 mouse constants, controller state/step encodings and the
// movement-packet record used by the host controller and its packet assembler.
package ps2_mouse_host_ctrl_pkg;

  localparam logic [7:0] PS2_CMD_RESET_CMD       = 8'hFF;
  localparam logic [7:0] PS2_CMD_GET_DEVICE_ID   = 8'hF2;
  localparam logic [7:0] PS2_CMD_SET_STREAM_MODE = 8'hEA;
  localparam logic [7:0] PS2_RD_ACK              = 8'hFA;
  localparam logic [7:0] PS2_RD_PASS             = 8'hAA;

  // Byte 1 of every movement packet has this bit set; used to find packet start.
  localparam int BYTE1_SYNC_BIT = 3;

  typedef enum logic [2:0] {
    ST_SEND_CMD,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_PASS,
    ST_WAIT_ID,
    ST_STREAM,
    ST_ERROR
  } ctrl_state_e;

  typedef enum logic [1:0] {
    STEP_RESET,
    STEP_GET_ID,
    STEP_SET_STREAM
  } init_step_e;

  typedef struct packed {
    logic       btn_l;
    logic       btn_m;
    logic       btn_r;
    logic       x_ov;
    logic       y_ov;
    logic [8:0] dx;
    logic [8:0] dy;
  } mouse_pkt_t;

  function automatic logic [7:0] step_cmd(input init_step_e step);
    logic [7:0] cmd;
    case (step)
      STEP_GET_ID:     cmd = PS2_CMD_GET_DEVICE_ID;
      STEP_SET_STREAM: cmd = PS2_CMD_SET_STREAM_MODE;
      default:         cmd = PS2_CMD_RESET_CMD;
    endcase
    return cmd;
  endfunction

  // Byte 1 layout: {y_ov, x_ov, ysign, xsign, 1, m, r, l}
  function automatic mouse_pkt_t decode_pkt(input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
    mouse_pkt_t p;
    p.btn_l = b1[0];
    p.btn_r = b1[1];
    p.btn_m = b1[2];
    p.x_ov  = b1[6];
    p.y_ov  = b1[7];
    p.dx    = {b1[4], b2};
    p.dy    = {b1[5], b3};
    return p;
  endfunction

endpackage

// File: rtl/ps2_mouse_host_ctrl_pkt_asm.sv
// Movement-packet assembler: collects three stream bytes, resyncs on byte-1
// sync bit and inter-byte timeout, and registers the decoded packet.
module ps2_mouse_pkt_asm
  import ps2_mouse_host_ctrl_pkg::*;
#(
  parameter int PKT_TIMEOUT = 100000,
  parameter int TMR_W       = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       pkt_valid,
  output mouse_pkt_t pkt
);

  localparam logic [TMR_W-1:0] PKT_LIM = TMR_W'(PKT_TIMEOUT);

  logic [1:0]       pkt_idx;
  logic [TMR_W-1:0] timer;
  logic [7:0]       byte1;
  logic [7:0]       byte2;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_idx   <= 2'd0;
      timer     <= '0;
      byte1     <= '0;
      byte2     <= '0;
      pkt_valid <= 1'b0;
      pkt       <= '0;
    end else begin
      pkt_valid <= 1'b0;
      if (!en) begin
        pkt_idx <= 2'd0;
        timer   <= '0;
      end else if (rx_done) begin
        timer <= '0;
        case (pkt_idx)
          2'd0: begin
            // Bytes without the sync bit cannot start a packet; drop them.
            if (rx_data[BYTE1_SYNC_BIT]) begin
              byte1   <= rx_data;
              pkt_idx <= 2'd1;
            end
          end
          2'd1: begin
            byte2   <= rx_data;
            pkt_idx <= 2'd2;
          end
          default: begin
            pkt_idx   <= 2'd0;
            pkt_valid <= 1'b1;
            pkt       <= decode_pkt(byte1, byte2, rx_data);
          end
        endcase
      end else if (pkt_idx != 2'd0) begin
        if (timer == PKT_LIM) begin
          pkt_idx <= 2'd0;
          timer   <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_host_ctrl.sv
// Host-side PS/2 mouse controller: runs the reset / get-ID / stream-enable
// handshake with retries, then hands stream bytes to the packet assembler.
module ps2_mouse_host_ctrl
  import ps2_mouse_host_ctrl_pkg::*;
#(
  parameter int RESP_TIMEOUT = 2500000,
  parameter int PKT_TIMEOUT  = 100000,
  parameter int MAX_RETRY    = 3,
  parameter int TMR_W        = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reinit,
  output logic [7:0] tx_data,
  output logic       tx_stb,
  input  logic       tx_ready,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       init_done,
  output logic       init_err,
  output logic [7:0] device_id,
  output logic       pkt_valid,
  output logic       btn_l,
  output logic       btn_m,
  output logic       btn_r,
  output logic       x_ov,
  output logic       y_ov,
  output logic [8:0] dx,
  output logic [8:0] dy
);

  localparam int               RTY_W    = $clog2(MAX_RETRY + 1);
  localparam logic [TMR_W-1:0] RESP_LIM = TMR_W'(RESP_TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  ctrl_state_e      state, state_n;
  init_step_e       step, step_n;
  logic [RTY_W-1:0] retry, retry_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [7:0]       tx_data_n;
  logic [7:0]       device_id_n;
  logic             tx_stb_n;
  logic             fail;
  logic             resp_expired;
  logic             stream_en;
  mouse_pkt_t       pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEND_CMD;
      step      <= STEP_RESET;
      retry     <= '0;
      timer     <= '0;
      tx_stb    <= 1'b0;
      tx_data   <= '0;
      device_id <= '0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      retry     <= retry_n;
      timer     <= timer_n;
      tx_stb    <= tx_stb_n;
      tx_data   <= tx_data_n;
      device_id <= device_id_n;
    end
  end

  always_comb begin
    state_n      = state;
    step_n       = step;
    retry_n      = retry;
    timer_n      = timer;
    tx_stb_n     = 1'b0;
    tx_data_n    = tx_data;
    device_id_n  = device_id;
    fail         = 1'b0;
    resp_expired = (timer == RESP_LIM);

    if (reinit) begin
      state_n = ST_SEND_CMD;
      step_n  = STEP_RESET;
      retry_n = '0;
      timer_n = '0;
    end else begin
      case (state)
        ST_SEND_CMD: begin
          timer_n = '0;
          if (tx_ready) begin
            tx_stb_n  = 1'b1;
            tx_data_n = step_cmd(step);
            state_n   = ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          // Stray rx bytes here are ignored; the response window opens on tx_done.
          timer_n = timer + 1'b1;
          if (tx_done) begin
            timer_n = '0;
            state_n = ST_WAIT_ACK;
          end else if (resp_expired) begin
            fail = 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          timer_n = timer + 1'b1;
          if (rx_done) begin
            if (rx_data == PS2_RD_ACK) begin
              timer_n = '0;
              case (step)
                STEP_RESET:  state_n = ST_WAIT_PASS;
                STEP_GET_ID: state_n = ST_WAIT_ID;
                default:     state_n = ST_STREAM;
              endcase
            end else begin
              fail = 1'b1;
            end
          end else if (resp_expired) begin
            fail = 1'b1;
          end
        end
        ST_WAIT_PASS: begin
          timer_n = timer + 1'b1;
          if (rx_done) begin
            if (rx_data == PS2_RD_PASS) begin
              timer_n = '0;
              state_n = ST_WAIT_ID;
            end else begin
              fail = 1'b1;
            end
          end else if (resp_expired) begin
            fail = 1'b1;
          end
        end
        ST_WAIT_ID: begin
          timer_n = timer + 1'b1;
          if (rx_done) begin
            timer_n     = '0;
            device_id_n = rx_data;
            state_n     = ST_SEND_CMD;
            if (step == STEP_RESET) begin
              step_n = STEP_GET_ID;
            end else begin
              step_n = STEP_SET_STREAM;
            end
          end else if (resp_expired) begin
            fail = 1'b1;
          end
        end
        default: begin
        end
      endcase

      // Any failure restarts the whole handshake from the reset command.
      if (fail) begin
        retry_n = retry + 1'b1;
        step_n  = STEP_RESET;
        timer_n = '0;
        if (retry == RTY_LAST) begin
          state_n = ST_ERROR;
        end else begin
          state_n = ST_SEND_CMD;
        end
      end
    end
  end

  assign init_done = (state == ST_STREAM);
  assign init_err  = (state == ST_ERROR);
  assign stream_en = (state == ST_STREAM) && !reinit;

  ps2_mouse_pkt_asm #(
    .PKT_TIMEOUT(PKT_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_pkt_asm (
    .clk      (clk),
    .rst      (rst),
    .en       (stream_en),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .pkt_valid(pkt_valid),
    .pkt      (pkt)
  );

  assign btn_l = pkt.btn_l;
  assign btn_m = pkt.btn_m;
  assign btn_r = pkt.btn_r;
  assign x_ov  = pkt.x_ov;
  assign y_ov  = pkt.y_ov;
  assign dx    = pkt.dx;
  assign dy    = pkt.dy;

endmodule
